// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider with signed/unsigned modes and annul, serving the EX divide handshake.
module div_seq #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);
  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;
  localparam int CW = $clog2(DATA_W + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DATA_W-1:0] dend, dend_n, dsr, dsr_n, rem, rem_n;
  logic [DATA_W-1:0] mag1, mag2, quo_fix, rem_fix;
  logic sign_q, sign_q_n, sign_r, sign_r_n, ready_n;
  logic [2*DATA_W-1:0] result_n;
  logic [DATA_W:0] partial, diff;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FREE;
      cnt      <= '0;
      dend     <= '0;
      dsr      <= '0;
      rem      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      ready_o  <= 1'b0;
      result_o <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      dend     <= dend_n;
      dsr      <= dsr_n;
      rem      <= rem_n;
      sign_q   <= sign_q_n;
      sign_r   <= sign_r_n;
      ready_o  <= ready_n;
      result_o <= result_n;
    end
  end
  // dend doubles as the quotient: dividend bits shift out the top as quotient bits shift in the bottom
  always_comb begin
    mag1     = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    mag2     = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    partial  = {rem, dend[DATA_W-1]};
    diff     = partial - {1'b0, dsr};
    quo_fix  = sign_q ? -dend : dend;
    rem_fix  = sign_r ? -rem : rem;
    state_n  = state;
    cnt_n    = cnt;
    dend_n   = dend;
    dsr_n    = dsr;
    rem_n    = rem;
    sign_q_n = sign_q;
    sign_r_n = sign_r;
    ready_n  = ready_o;
    result_n = result_o;
    case (state)
      S_FREE: begin
        if (start_i && !annul_i) begin
          dend_n   = mag1;
          dsr_n    = mag2;
          rem_n    = '0;
          cnt_n    = '0;
          sign_q_n = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          sign_r_n = signed_div_i & opdata1_i[DATA_W-1];
          state_n  = (opdata2_i == '0) ? S_BYZERO : S_ON;
        end
      end
      S_BYZERO: begin
        state_n  = annul_i ? S_FREE : S_END;
        ready_n  = !annul_i;
        result_n = '0;
      end
      S_ON: begin
        if (annul_i) begin
          state_n  = S_FREE;
          cnt_n    = '0;
          ready_n  = 1'b0;
          result_n = '0;
        end else if (cnt == CW'(DATA_W)) begin
          state_n  = S_END;
          ready_n  = 1'b1;
          result_n = {rem_fix, quo_fix};
        end else begin
          rem_n  = diff[DATA_W] ? partial[DATA_W-1:0] : diff[DATA_W-1:0];
          dend_n = {dend[DATA_W-2:0], ~diff[DATA_W]};
          cnt_n  = cnt + 1'b1;
        end
      end
      default: begin
        if (!start_i) begin
          state_n  = S_FREE;
          ready_n  = 1'b0;
          result_n = '0;
        end
      end
    endcase
  end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: table-driven divide vectors with a result scoreboard, plus annul and async-reset sequences.
module tb_div_seq;
  logic        clk, rst, signed_div, start, annul;
  logic [31:0] op1, op2;
  logic [63:0] result;
  logic        ready;
  int          n_chk, n_fail;
  logic [63:0] exp_q[$];

  typedef struct {
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
  } vec_t;
  vec_t vecs[10];

  div_seq #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div), .opdata1_i(op1), .opdata2_i(op2),
    .start_i(start), .annul_i(annul), .result_o(result), .ready_o(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic do_div(input logic sd, input logic [31:0] a, input logic [31:0] b, input logic [63:0] res);
    int lat;
    logic [63:0] e;
    exp_q.push_back(res);
    signed_div = sd;
    op1 = a;
    op2 = b;
    start = 1'b1;
    @(negedge clk);
    op1 = $urandom;
    op2 = $urandom;
    signed_div = ~sd;
    lat = 0;
    while (!ready && lat < 60) begin
      if (result !== 64'h0) chk("result_zero_while_busy", result, 64'h0);
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), (b == 32'h0) ? 64'd1 : 64'd33);
    e = exp_q.pop_front();
    chk("result", result, e);
    @(negedge clk);
    chk("ready_held", {63'h0, ready}, 64'h1);
    chk("result_held", result, e);
    start = 1'b0;
    @(negedge clk);
    chk("ready_drop", {63'h0, ready}, 64'h0);
    chk("result_drop", result, 64'h0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    vecs[0] = '{1'b0, 32'd7,        32'd2,        {32'h00000001, 32'h00000003}};
    vecs[1] = '{1'b1, 32'hFFFFFFF9, 32'h00000002, {32'hFFFFFFFF, 32'hFFFFFFFD}};
    vecs[2] = '{1'b0, 32'hFFFFFFF9, 32'h00000002, {32'h00000001, 32'h7FFFFFFC}};
    vecs[3] = '{1'b1, 32'd5,        32'd0,        64'h0};
    vecs[4] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}};
    vecs[5] = '{1'b0, 32'd100,      32'd7,        {32'h00000002, 32'h0000000E}};
    vecs[6] = '{1'b1, 32'd7,        32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}};
    vecs[7] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'h0000000E}};
    vecs[8] = '{1'b0, 32'd0,        32'd5,        64'h0};
    vecs[9] = '{1'b0, 32'd5,        32'd0,        64'h0};
    rst = 1'b1;
    start = 1'b0;
    annul = 1'b0;
    signed_div = 1'b0;
    op1 = '0;
    op2 = '0;
    repeat (2) @(negedge clk);
    chk("reset_ready", {63'h0, ready}, 64'h0);
    chk("reset_result", result, 64'h0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) do_div(vecs[i].sd, vecs[i].a, vecs[i].b, vecs[i].res);
    // start with annul held must be ignored; then annul 10 cycles into ON
    signed_div = 1'b0;
    op1 = 32'd7;
    op2 = 32'd2;
    start = 1'b1;
    annul = 1'b1;
    repeat (3) @(negedge clk);
    chk("annul_start_ignored", {63'h0, ready}, 64'h0);
    annul = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("annul_no_ready", {63'h0, ready}, 64'h0);
    end
    annul = 1'b1;
    @(negedge clk);
    chk("annul_ready", {63'h0, ready}, 64'h0);
    chk("annul_result", result, 64'h0);
    annul = 1'b0;
    do_div(1'b0, 32'd100, 32'd7, {32'h00000002, 32'h0000000E});
    // annul in END is ignored
    signed_div = 1'b0;
    op1 = 32'd7;
    op2 = 32'd2;
    start = 1'b1;
    repeat (35) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    chk("end_annul_ready", {63'h0, ready}, 64'h1);
    chk("end_annul_result", result, {32'h1, 32'h3});
    annul = 1'b0;
    // async reset while result held clears outputs immediately
    #2 rst = 1'b1;
    #1;
    chk("rst_end_ready", {63'h0, ready}, 64'h0);
    chk("rst_end_result", result, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    // async reset mid-ON
    op1 = 32'd100;
    op2 = 32'd3;
    start = 1'b1;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_on_ready", {63'h0, ready}, 64'h0);
    chk("rst_on_result", result, 64'h0);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    do_div(1'b0, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
